sobel_window_gen: RTL

- Producer side of the 3x3 window interface used by the Sobel convolution stage.
- Accepts a raster pixel stream, one 8-bit pixel per cycle.
- Stores four lines in rotating line buffers. Once three full lines are held, it emits one 72-bit 3x3 window per cycle for a whole line.
- Pulses o_intr after each emitted line so the upstream DMA/driver can send the next line.

---
 rtl/sobel_window_gen_pkg.sv | 15 +
 rtl/sobel_window_gen_if.sv | 26 ++
 rtl/sobel_window_gen_line_buffer.sv | 32 +++
 rtl/sobel_window_gen.sv | 127 ++++++++++++
 4 files changed

// File: rtl/sobel_window_gen_pkg.sv
// Shared widths and FSM encoding for the Sobel 3x3 window generator.
package sobel_pkg;

  localparam int unsigned PIXEL_W  = 8;
  localparam int unsigned WIN_TAPS = 9;
  localparam int unsigned WIN_W    = PIXEL_W * WIN_TAPS;
  localparam int unsigned ROW_W    = 3 * PIXEL_W;
  localparam int unsigned NUM_BUFS = 4;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_e;

endpackage

// File: rtl/sobel_window_gen_if.sv
// Pixel stream in, 3x3 window stream and line-done interrupt out.
interface sobel_window_gen_if;

  logic [sobel_pkg::PIXEL_W-1:0] i_pixel_data;
  logic                          i_pixel_data_valid;
  logic [sobel_pkg::WIN_W-1:0]   o_pixel_data;
  logic                          o_pixel_data_valid;
  logic                          o_intr;

  modport slave (
    input  i_pixel_data,
    input  i_pixel_data_valid,
    output o_pixel_data,
    output o_pixel_data_valid,
    output o_intr
  );

  modport master (
    output i_pixel_data,
    output i_pixel_data_valid,
    input  o_pixel_data,
    input  o_pixel_data_valid,
    input  o_intr
  );

endinterface

// File: rtl/sobel_window_gen_line_buffer.sv
// One image line of pixels; single write port, three adjacent combinational read taps.
module line_buffer
  import sobel_pkg::*;
#(
  parameter  int unsigned LINE_WIDTH = 512,
  localparam int unsigned AW         = $clog2(LINE_WIDTH)
) (
  input  logic               i_clk,
  input  logic [PIXEL_W-1:0] wr_data,
  input  logic               wr_valid,
  input  logic [AW-1:0]      wr_addr,
  input  logic [AW-1:0]      rd_addr,
  output logic [ROW_W-1:0]   rd_taps
);

  logic [PIXEL_W-1:0] mem [LINE_WIDTH];
  logic [AW-1:0]      addr1;
  logic [AW-1:0]      addr2;

  // Pixel storage; contents are never cleared.
  always_ff @(posedge i_clk) begin
    if (wr_valid) mem[wr_addr] <= wr_data;
  end

  // Taps at rd_addr, +1, +2 with wrap to the start of the line.
  always_comb begin
    addr1   = (rd_addr == AW'(LINE_WIDTH - 1)) ? '0 : rd_addr + AW'(1);
    addr2   = (addr1   == AW'(LINE_WIDTH - 1)) ? '0 : addr1   + AW'(1);
    rd_taps = {mem[addr2], mem[addr1], mem[rd_addr]};
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Rotating four-line buffer that emits one 3x3 window per cycle for a full line.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter  int unsigned LINE_WIDTH = 512,
  localparam int unsigned CNT_W      = $clog2(4 * LINE_WIDTH + 1)
) (
  input logic               i_clk,
  input logic               i_rst,
  sobel_window_gen_if.slave bus
);

  localparam int unsigned AW = $clog2(LINE_WIDTH);

  state_e           state, state_d;
  logic [AW-1:0]    wp, rp, rp_d, rd_col;
  logic [1:0]       wb, rb, rb_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             wr_en, emit, valid_d, intr_d;
  logic [ROW_W-1:0] taps [NUM_BUFS];
  logic [WIN_W-1:0] window_c;

  assign wr_en = bus.i_pixel_data_valid && !i_rst;

  for (genvar b = 0; b < int'(NUM_BUFS); b++) begin : g_buf
    line_buffer #(.LINE_WIDTH(LINE_WIDTH)) u_buf (
      .i_clk    (i_clk),
      .wr_data  (bus.i_pixel_data),
      .wr_valid (wr_en && (wb == 2'(b))),
      .wr_addr  (wp),
      .rd_addr  (rd_col),
      .rd_taps  (taps[b])
    );
  end

  // Row r of the window comes from buffer rb+r (mod 4).
  always_comb begin
    window_c = '0;
    for (int r = 0; r < 3; r++) begin
      window_c[r*ROW_W +: ROW_W] = taps[2'(rb + 2'(r))];
    end
  end

  // Occupancy: +1 per accepted pixel, -1 per emitted window.
  always_comb begin
    cnt_d = cnt;
    case ({wr_en, emit})
      2'b10:   cnt_d = cnt + CNT_W'(1);
      2'b01:   cnt_d = cnt - CNT_W'(1);
      default: cnt_d = cnt;
    endcase
  end

  // Write pointer and buffer rotation, plus the occupancy register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wp  <= '0;
      wb  <= '0;
      cnt <= '0;
    end else begin
      if (wr_en) begin
        if (wp == AW'(LINE_WIDTH - 1)) begin
          wp <= '0;
          wb <= wb + 2'(1);
        end else begin
          wp <= wp + AW'(1);
        end
      end
      cnt <= cnt_d;
    end
  end

  // Next state: start a burst once three lines are held; the edge after the last window ends it.
  always_comb begin
    state_d = state;
    rp_d    = rp;
    rb_d    = rb;
    rd_col  = rp;
    emit    = 1'b0;
    valid_d = 1'b0;
    intr_d  = 1'b0;
    case (state)
      IDLE: begin
        if (cnt >= CNT_W'(3 * LINE_WIDTH)) begin
          state_d = READ;
          rp_d    = '0;
          rd_col  = '0;
          emit    = 1'b1;
          valid_d = 1'b1;
        end
      end
      READ: begin
        if (rp == AW'(LINE_WIDTH - 1)) begin
          state_d = IDLE;
          rb_d    = rb + 2'(1);
          intr_d  = 1'b1;
        end else begin
          rd_col  = rp + AW'(1);
          rp_d    = rp + AW'(1);
          emit    = 1'b1;
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, read pointers and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state                  <= IDLE;
      rp                     <= '0;
      rb                     <= '0;
      bus.o_pixel_data       <= '0;
      bus.o_pixel_data_valid <= 1'b0;
      bus.o_intr             <= 1'b0;
    end else begin
      state <= state_d;
      rp    <= rp_d;
      rb    <= rb_d;
      if (emit) bus.o_pixel_data <= window_c;
      bus.o_pixel_data_valid <= valid_d;
      bus.o_intr             <= intr_d;
    end
  end

endmodule
